// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, counter width,
// frame lengths and the clocks-per-bit derivation.
package uart_pkg;

    localparam int unsigned CNT_W          = 18;
    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned FRAME_BITS_PAR = 11;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TX_START_BIT  = 3'd1,
        TX_DATA_BITS  = 3'd2,
        TX_PARITY_BIT = 3'd3,
        TX_STOP_BIT   = 3'd4,
        CLEANUP       = 3'd5
    } uart_state_e;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle between user logic and uart_tx.
// The slave side is the transmitter, the master side the user logic.
interface uart_tx_if;

    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Active;
    logic       o_TX_Serial;
    logic       o_TX_Done;
    logic       o_TX_Ready;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Active,
        input  o_TX_Serial,
        input  o_TX_Done,
        input  o_TX_Ready
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Active,
        output o_TX_Serial,
        output o_TX_Done,
        output o_TX_Ready
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-cell counter: counts 0..CLOCKS_PER_BIT-1 and wraps, with a
// synchronous clear. o_Tc marks the last cycle of a bit cell.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 434
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clear,
    output logic o_Tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    assign o_Tc = (r_count == TC_VAL);

    // Count cycles within a bit cell, restarting at terminal count
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_count <= '0;
        end else if (i_Clear || o_Tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity cell (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK       = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic     i_Clock,
    input  logic     i_Rst_n,
    uart_tx_if.slave tx_if
);

    localparam int unsigned CLOCKS_PER_BIT = clks_per_bit(CLK, BAUD_RATE);

    uart_state_e r_state;
    uart_state_e w_state_nxt;
    logic [2:0]  r_index;
    logic [2:0]  w_index_nxt;
    logic [7:0]  r_data;
    logic [7:0]  w_data_nxt;
    logic        r_serial;
    logic        w_serial_nxt;
    logic        r_active;
    logic        w_active_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_ready;
    logic        w_ready_nxt;
    logic        w_tc;
    logic        w_clear;

    // Counter is held at zero whenever no bit cell is being timed
    assign w_clear = (r_state == IDLE) || (r_state == CLEANUP);

    uart_baud_cnt #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud_cnt (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .i_Clear(w_clear),
        .o_Tc   (w_tc)
    );

    // Next-state, next-output decode; outputs follow the next state
    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_data_nxt   = r_data;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;
        w_serial_nxt = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_index_nxt  = '0;
                w_active_nxt = 1'b0;
                if (tx_if.i_TX_DV) begin
                    w_data_nxt   = tx_if.i_TX_Byte;
                    w_active_nxt = 1'b1;
                    w_state_nxt  = TX_START_BIT;
                end
            end
            TX_START_BIT: begin
                if (w_tc) begin
                    w_state_nxt = TX_DATA_BITS;
                end
            end
            TX_DATA_BITS: begin
                if (w_tc) begin
                    if (r_index == 3'd7) begin
                        w_index_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = TX_PARITY_BIT;
`else
                        w_state_nxt = TX_STOP_BIT;
`endif
                    end else begin
                        w_index_nxt = r_index + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY_BIT: begin
                if (w_tc) begin
                    w_state_nxt = TX_STOP_BIT;
                end
            end
`endif
            TX_STOP_BIT: begin
                if (w_tc) begin
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = CLEANUP;
                end
            end
            CLEANUP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_index_nxt  = '0;
                w_active_nxt = 1'b0;
                w_state_nxt  = IDLE;
            end
        endcase

        unique case (w_state_nxt)
            TX_START_BIT:  w_serial_nxt = 1'b0;
            TX_DATA_BITS:  w_serial_nxt = w_data_nxt[w_index_nxt];
`ifdef UART_TX_PARITY_EN
            TX_PARITY_BIT: w_serial_nxt = ^w_data_nxt;
`endif
            default:       w_serial_nxt = 1'b1;
        endcase

        w_ready_nxt = (w_state_nxt == IDLE);
    end

    // State and registered outputs; reset drives the line high at once
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_data   <= '0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_index  <= w_index_nxt;
            r_data   <= w_data_nxt;
            r_serial <= w_serial_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign tx_if.o_TX_Serial = r_serial;
    assign tx_if.o_TX_Active = r_active;
    assign tx_if.o_TX_Done   = r_done;
    assign tx_if.o_TX_Ready  = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: line decoder + scoreboard of sent bytes.
// Build with UART_TX_PARITY_EN to also cover the parity cell.
module tb_uart_tx;

    localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0;
    int   exp_done = 0;

    logic [7:0] sb_q[$];

    uart_tx_if bus();

    uart_tx #(
        .CLK      (50_000_000),
        .BAUD_RATE(115200)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .tx_if  (bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    // Line decoder: samples mid-cell, compares against the scoreboard
    int         m_cnt;
    int         m_start = 0;
    int         m_cell;
    bit         m_busy = 1'b0;
    logic [7:0] m_rx;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (m_busy && sb_q.size() != 0) void'(sb_q.pop_front());
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.o_TX_Serial == 1'b0) begin
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_start = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
                m_cell = m_cnt / CPB;
                if (m_cell == 0) begin
                    chk("start_bit", 32'(bus.o_TX_Serial), 0);
                    chk("active", 32'(bus.o_TX_Active), 1);
                    chk("busy_rdy", 32'(bus.o_TX_Ready), 0);
                end else if (m_cell <= 8) begin
                    m_rx[m_cell-1] = bus.o_TX_Serial;
`ifdef UART_TX_PARITY_EN
                end else if (m_cell == 9) begin
                    if (sb_q.size() != 0)
                        chk("parity", 32'(bus.o_TX_Serial), 32'(^sb_q[0]));
`endif
                end else begin
                    chk("stop_bit", 32'(bus.o_TX_Serial), 1);
                    chk("sb_empty", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0)
                        chk("rx_byte", 32'(m_rx), 32'(sb_q.pop_front()));
                    exp_done++;
                    m_busy = 1'b0;
                end
            end
        end
        if (rst_n && bus.o_TX_Done) begin
            n_done++;
            chk("done_lat", 32'(cyc - m_start), 32'(FRAME * CPB));
        end
    end

    // Strobe for one cycle; caller is aligned to a falling edge
    task automatic send(input logic [7:0] b, input bit push);
        bus.i_TX_DV   = 1'b1;
        bus.i_TX_Byte = b;
        if (push) sb_q.push_back(b);
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while ((sb_q.size() != 0 || bus.o_TX_Ready !== 1'b1) && i < max) begin
            @(negedge clk);
            i++;
        end
        chk("drain_to", 32'(i < max), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle", {bus.o_TX_Serial, bus.o_TX_Ready,
                         bus.o_TX_Active, bus.o_TX_Done}, 4'b1100);
        end
    endtask

    initial begin
        bus.i_TX_DV   = 1'b0;
        bus.i_TX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_state", {bus.o_TX_Serial, bus.o_TX_Ready,
                          bus.o_TX_Active, bus.o_TX_Done}, 4'b1100);
        rst_n = 1'b1;
        idle_check(1000);

        // Single frame, then a strobe ignored mid-frame
        @(negedge clk);
        send(8'hA5, 1'b1);
        chk("rdy_low", 32'(bus.o_TX_Ready), 0);
        repeat (99) @(negedge clk);
        send(8'h3C, 1'b0);
        wait_drain(3 * FRAME * CPB);

        // Minimum strobe spacing
        @(negedge clk);
        send(8'h00, 1'b1);
        repeat (FRAME * CPB) @(negedge clk);
        @(negedge clk);
        chk("rdy_min", 32'(bus.o_TX_Ready), 1);
        send(8'hFF, 1'b1);
        wait_drain(3 * FRAME * CPB);

        // Strobe held high: two back-to-back frames of the same byte
        @(negedge clk);
        bus.i_TX_DV   = 1'b1;
        bus.i_TX_Byte = 8'h81;
        sb_q.push_back(8'h81);
        sb_q.push_back(8'h81);
        repeat (FRAME * CPB + 3) @(negedge clk);
        bus.i_TX_DV = 1'b0;
        wait_drain(3 * FRAME * CPB);

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        send(8'h07, 1'b1);
        wait_drain(3 * FRAME * CPB);
        @(negedge clk);
        send(8'h03, 1'b1);
        wait_drain(3 * FRAME * CPB);
`endif

        // Reset in the middle of data bit 3
        @(negedge clk);
        send(8'h55, 1'b1);
        repeat (4 * CPB + 200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ser", 32'(bus.o_TX_Serial), 1);
        chk("rst_act", 32'(bus.o_TX_Active), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check(300);

        chk("done_cnt", 32'(n_done), 32'(exp_done));
        chk("sb_left", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
